// File: rtl/qeciphy_tx_framer.sv
// Transmit framer: builds 64-slot link frames (FAW + 9 groups of 6 data words and a CRC word)
// from a 64-bit valid/ready user stream, with FAW/CRC boundary strobes toward the PHY.
module qeciphy_tx_framer #(
  parameter logic [55:0] FAW_PATTERN = 56'hF0A5_C33C_5AA5_0F,
  parameter logic [63:0] IDLE_WORD   = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [63:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  input  logic        local_rx_rdy_i,
  output logic [63:0] tdata_o,
  output logic        faw_boundary_o,
  output logic        crc_boundary_o
);

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CRC_W    = 32;
  localparam int unsigned SLOT_W   = 6;
  localparam int unsigned POS_W    = 3;
  localparam int unsigned MASK_W   = 6;
  localparam int unsigned PAD_W    = DATA_W - CRC_W - MASK_W;
  localparam logic [POS_W-1:0] CRC_POS  = POS_W'(6);
  localparam logic [CRC_W-1:0] CRC_POLY = 32'h1EDC_6F41;
  localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SLOT_W-1:0]   r_slot;
  logic [POS_W-1:0]    r_pos;
  logic [CRC_W-1:0]    r_crc;
  logic [MASK_W-1:0]   r_mask;
  logic [DATA_W-1:0]   r_tdata;
  logic                r_faw;
  logic                r_crc_b;

  logic                w_is_faw;
  logic                w_is_crc;
  logic                w_is_data;
  logic                w_tready;
  logic                w_accept;
  logic [DATA_W-1:0]   w_data_word;
  logic [CRC_W-1:0]    w_crc_upd;
  logic [MASK_W-1:0]   w_mask_upd;
  logic [DATA_W-1:0]   w_word;

  // CRC-32C advanced MSB-first over one 64-bit word, no reflection
  function automatic logic [CRC_W-1:0] crc32c_word(input logic [CRC_W-1:0] crc_in,
                                                   input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable_i)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!enable_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot classification; the counter sits at 0 while idle, so the enabling cycle is slot 0
  assign w_is_faw  = (r_slot == '0);
  assign w_is_crc  = !w_is_faw && (r_pos == CRC_POS);
  assign w_is_data = !w_is_faw && !w_is_crc;

  // Reset gates ready so a beat is never taken in a cycle whose word is discarded
  assign w_tready   = (r_state == ST_RUN) && enable_i && !rst_i && w_is_data;
  assign s_tready_o = w_tready;
  assign w_accept   = s_tvalid_i && w_tready;

  assign w_data_word = w_accept ? s_tdata_i : IDLE_WORD;
  assign w_crc_upd   = crc32c_word(r_crc, w_data_word);
  assign w_mask_upd  = r_mask | (MASK_W'(w_accept) << r_pos);

  always_comb begin
    w_word = w_data_word;
    if (w_is_faw)      w_word = {FAW_PATTERN, 7'b0, local_rx_rdy_i};
    else if (w_is_crc) w_word = {PAD_W'(0), r_mask, r_crc};
  end

  // Slot/CRC bookkeeping and the one-cycle registered output stage
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      r_slot  <= '0;
      r_pos   <= '0;
      r_crc   <= CRC_INIT;
      r_mask  <= '0;
      r_tdata <= '0;
      r_faw   <= 1'b0;
      r_crc_b <= 1'b0;
    end else begin
      r_slot <= r_slot + SLOT_W'(1);
      if (w_is_faw || w_is_crc) r_pos <= '0;
      else                      r_pos <= r_pos + POS_W'(1);
      if (w_is_data) begin
        r_crc  <= w_crc_upd;
        r_mask <= w_mask_upd;
      end else begin
        r_crc  <= CRC_INIT;
        r_mask <= '0;
      end
      r_tdata <= w_word;
      r_faw   <= w_is_faw;
      r_crc_b <= w_is_crc;
    end
  end

  assign tdata_o        = r_tdata;
  assign faw_boundary_o = r_faw;
  assign crc_boundary_o = r_crc_b;

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Scoreboard bench for qeciphy_tx_framer: a slot-map/table-CRC reference model queues
// expected output words; a separate monitor pops and compares them one cycle later.
module tb_qeciphy_tx_framer;

  localparam logic [55:0] FAW = 56'hF0A5C33C5AA50F;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [63:0] s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0;
  logic        s_tready_o;
  logic        local_rx_rdy_i = 1'b0;
  logic [63:0] tdata_o;
  logic        faw_boundary_o;
  logic        crc_boundary_o;

  qeciphy_tx_framer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .s_tdata_i      (s_tdata_i),
    .s_tvalid_i     (s_tvalid_i),
    .s_tready_o     (s_tready_o),
    .local_rx_rdy_i (local_rx_rdy_i),
    .tdata_o        (tdata_o),
    .faw_boundary_o (faw_boundary_o),
    .crc_boundary_o (crc_boundary_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] word;
    logic        faw;
    logic        crc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats = 0;

  logic [31:0] crc_tbl[256];
  int          m_slot = 0;
  logic [63:0] m_words[6];
  logic [5:0]  m_mask = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise table CRC-32C over the six words of a group, MSB byte first
  function automatic logic [31:0] group_crc();
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int w = 0; w < 6; w++)
      for (int i = 7; i >= 0; i--) begin
        b = m_words[w][8*i +: 8];
        c = {c[23:0], 8'h00} ^ crc_tbl[c[31:24] ^ b];
      end
    return c;
  endfunction

  // Drive one cycle of inputs and queue the word the framer must emit for it
  task automatic step(input bit en, input bit rst, input bit vld,
                      input logic [63:0] d, input bit rdy);
    exp_t e;
    int   k;
    bit   exp_rdy;
    @(negedge clk);
    enable_i = en; rst_i = rst; s_tvalid_i = vld; s_tdata_i = d; local_rx_rdy_i = rdy;
    #1;
    e = '0;
    if (rst || !en) begin
      if (!rst) chk("tready_idle", 64'(s_tready_o), 64'(0));
      m_slot = 0;
      m_mask = '0;
    end else begin
      k = (m_slot - 1) % 7;
      exp_rdy = (m_slot != 0) && (k != 6);
      chk($sformatf("tready_slot%0d", m_slot), 64'(s_tready_o), 64'(exp_rdy));
      if (m_slot == 0) begin
        e.word = {FAW, 7'b0, rdy};
        e.faw  = 1'b1;
      end else if (k < 6) begin
        m_words[k] = vld ? d : 64'h0;
        m_mask[k]  = vld;
        if (vld) beats++;
        e.word = m_words[k];
      end else begin
        e.word = {26'b0, m_mask, group_crc()};
        e.crc  = 1'b1;
        m_mask = '0;
      end
      m_slot = (m_slot + 1) % 64;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Monitor: every cycle the DUT presents a registered word; compare with the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tdata", tdata_o, e.word);
        chk("faw_boundary", 64'(faw_boundary_o), 64'(e.faw));
        chk("crc_boundary", 64'(crc_boundary_o), 64'(e.crc));
      end
    end
  end

  initial begin
    logic [31:0] c;
    for (int b = 0; b < 256; b++) begin
      c = 32'(b) << 24;
      for (int i = 0; i < 8; i++) c = c[31] ? ({c[30:0], 1'b0} ^ 32'h1EDC6F41) : {c[30:0], 1'b0};
      crc_tbl[b] = c;
    end

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, rnd64(), 1'b1);
    chk("reset_tdata", tdata_o, 64'h0);
    chk("reset_faw", 64'(faw_boundary_o), 64'h0);
    chk("reset_crc", 64'(crc_boundary_o), 64'h0);
    chk("reset_tready", 64'(s_tready_o), 64'h0);

    // Two back-to-back frames with valid held high; rx-ready 0 then 1
    beats = 0;
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
    chk("beats_frame0", 64'(beats), 64'd54);
    beats = 0;
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
    chk("beats_frame1", 64'(beats), 64'd54);

    // Known data 1..6 in the first group
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, rnd64(), 1'b1);
    step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b1, 64'(i), 1'b1);
    for (int i = 0; i < 57; i++) step(1'b1, 1'b0, 1'($urandom), rnd64(), 1'b1);

    // Gaps at data positions 1 and 4 of group 0
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
    for (int p = 0; p < 6; p++) step(1'b1, 1'b0, !(p == 1 || p == 4), rnd64(), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom), rnd64(), 1'b0);

    // Disable at slot 20 for 5 cycles, then re-enable
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, rnd64(), 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, rnd64(), 1'b1);
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'($urandom), rnd64(), 1'($urandom));

    // Reset pulse at slot 40 while enabled
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
    step(1'b1, 1'b1, 1'b1, rnd64(), 1'b1);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b0, 1'($urandom), rnd64(), 1'b1);

    // Randomized traffic with occasional disables and resets
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 199) == 0,
           1'($urandom), rnd64(), 1'($urandom));

    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    @(posedge clk);
    #3;
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
